// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder control path.
//   TBL_DEF   : default traceback length (trellis steps per block)
//   CNT_W_DEF : step/bit counter width for the default TBL
//   PM_W      : path-metric width shared by PMU and TBU
//   vctrl_state_t : block scheduler FSM states
package viterbi_pkg;
  localparam int TBL_DEF   = 15;
  localparam int CNT_W_DEF = $clog2(TBL_DEF + 1);
  localparam int PM_W      = 8;

  typedef enum logic [2:0] {
    ACCUM,
    FLUSH,
    WAIT_PM,
    START_TB,
    TRACE
  } vctrl_state_t;
endpackage

// File: rtl/tb_watchdog.sv
// Traceback watchdog: counts cycles spent in TRACE and flags a hung TBU.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the counter (issued with the TBU start pulse)
//   en         : count this cycle (state is TRACE)
//   timeout    : this enabled cycle is the TB_TIMEOUT-th since clr
module tb_watchdog #(
  parameter int TB_TIMEOUT = 34,
  parameter int W          = $clog2(TB_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   wd_cnt <= '0;
    else if (clr) wd_cnt <= '0;
    else if (en)  wd_cnt <= wd_cnt + 1'b1;
  end

  // Fires when the incremented count would reach TB_TIMEOUT.
  assign timeout = en && (wd_cnt == W'(TB_TIMEOUT - 1));
endmodule

// File: rtl/viterbi_ctrl.sv
// Block scheduler for the Viterbi datapath. Accepts symbols, strobes the
// ACS/PMU once per trellis step, pads short final blocks with flush steps,
// launches traceback and marks which serial TBU bits are payload.
//   sym_valid_i/sym_last_i/sym_ready_o : upstream symbol handshake
//   acs_valid_o, pm_init_o, flush_o    : per-step strobes to BMU/ACSU/PMU
//   tbu_start_o, tbu_bit_valid_i       : traceback launch / serial bit valid
//   out_keep_o                         : current TBU bit is payload
//   blk_done_o, busy_o, err_o          : block done pulse, not-ACCUM, sticky timeout
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int TBL        = TBL_DEF,
  parameter int TB_TIMEOUT = 2 * TBL + 4,
  parameter int CNT_W      = $clog2(TBL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sym_valid_i,
  input  logic sym_last_i,
  output logic sym_ready_o,
  output logic acs_valid_o,
  output logic pm_init_o,
  output logic flush_o,
  output logic tbu_start_o,
  input  logic tbu_bit_valid_i,
  output logic out_keep_o,
  output logic blk_done_o,
  output logic busy_o,
  output logic err_o
);
  localparam logic [CNT_W-1:0] TBL_C = CNT_W'(TBL);

  vctrl_state_t     state, state_nxt;
  logic [CNT_W-1:0] step_cnt, bit_cnt, blk_len;
  logic [CNT_W-1:0] step_inc, bit_inc;
  logic             first_r, fire, bit_last, timeout, tb_abort;

  assign step_inc = step_cnt + 1'b1;
  assign bit_inc  = bit_cnt + 1'b1;

  // Gated by rst_n so the handshake stays quiet while reset is held.
  assign sym_ready_o = rst_n && (state == ACCUM);
  assign busy_o      = (state != ACCUM);
  assign fire        = sym_valid_i && sym_ready_o;

  assign bit_last = (state == TRACE) && tbu_bit_valid_i && (bit_inc == TBL_C);
  // A real final bit wins over a coincident watchdog expiry.
  assign tb_abort = timeout && !bit_last;

  tb_watchdog #(.TB_TIMEOUT(TB_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == START_TB),
    .en      (state == TRACE),
    .timeout (timeout)
  );

  always_comb begin
    state_nxt   = state;
    acs_valid_o = 1'b0;
    pm_init_o   = 1'b0;
    flush_o     = 1'b0;
    tbu_start_o = 1'b0;
    out_keep_o  = 1'b0;
    blk_done_o  = 1'b0;
    case (state)
      ACCUM: if (fire) begin
        acs_valid_o = 1'b1;
        pm_init_o   = first_r;
        if (step_inc == TBL_C) state_nxt = WAIT_PM;
        else if (sym_last_i)   state_nxt = FLUSH;
      end
      FLUSH: begin
        acs_valid_o = 1'b1;
        flush_o     = 1'b1;
        if (step_inc == TBL_C) state_nxt = WAIT_PM;
      end
      WAIT_PM:  state_nxt = START_TB;
      START_TB: begin
        tbu_start_o = 1'b1;
        state_nxt   = TRACE;
      end
      TRACE: begin
        // Newest step comes out first, so the padding bits lead.
        out_keep_o = tbu_bit_valid_i && (bit_cnt >= (TBL_C - blk_len));
        if (bit_last || timeout) begin
          blk_done_o = 1'b1;
          state_nxt  = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      step_cnt <= '0;
      bit_cnt  <= '0;
      blk_len  <= '0;
      first_r  <= 1'b1;
      err_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: if (fire) begin
          first_r  <= sym_last_i;
          step_cnt <= step_inc;
          if (step_inc == TBL_C) blk_len <= TBL_C;
          else if (sym_last_i)   blk_len <= step_inc;
        end
        FLUSH:    step_cnt <= step_inc;
        START_TB: bit_cnt  <= '0;
        TRACE: begin
          if (tbu_bit_valid_i) bit_cnt <= bit_inc;
          if (blk_done_o) step_cnt <= '0;
          if (tb_abort) begin
            err_o   <= 1'b1;
            first_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl (TBL=15): full block, short frame,
// multi-block frames, upstream gaps, TBU hang and reset mid-trace.
module tb_viterbi_ctrl;
  localparam int TBL        = 15;
  localparam int TB_TIMEOUT = 34;

  logic clk, rst_n;
  logic sym_valid_i, sym_last_i, sym_ready_o;
  logic acs_valid_o, pm_init_o, flush_o, tbu_start_o;
  logic tbu_bit_valid_i, out_keep_o, blk_done_o, busy_o, err_o;

  int n_chk = 0;
  int n_fail = 0;

  viterbi_ctrl #(.TBL(TBL), .TB_TIMEOUT(TB_TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sym_valid_i     (sym_valid_i),
    .sym_last_i      (sym_last_i),
    .sym_ready_o     (sym_ready_o),
    .acs_valid_o     (acs_valid_o),
    .pm_init_o       (pm_init_o),
    .flush_o         (flush_o),
    .tbu_start_o     (tbu_start_o),
    .tbu_bit_valid_i (tbu_bit_valid_i),
    .out_keep_o      (out_keep_o),
    .blk_done_o      (blk_done_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic v, input logic l, input logic b);
    @(negedge clk);
    sym_valid_i = v; sym_last_i = l; tbu_bit_valid_i = b;
    #1;
  endtask

  function automatic logic [8:0] outs();
    return {sym_ready_o, acs_valid_o, pm_init_o, flush_o, tbu_start_o,
            out_keep_o, blk_done_o, busy_o, err_o};
  endfunction

  // n accepted symbols; optional last on the final one; optional idle gaps.
  task automatic feed(input int n, input bit last, input bit first_exp, input bit gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, last && (i == n - 1), 1'b0);
      chk("acs_on_fire", acs_valid_o, 1);
      chk("pm_init", pm_init_o, first_exp && (i == 0));
      chk("no_flush", flush_o, 0);
      if (gap && i < n - 1) begin
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_acs", acs_valid_o, 0);
        chk("gap_ready", sym_ready_o, 1);
      end
    end
  endtask

  // Called right after a block's final acs_valid_o.
  task automatic trace_blk(input int pad, input bit gap);
    drive(1'b0, 1'b0, 1'b0);
    chk("wait_pm_start", tbu_start_o, 0);
    chk("wait_pm_busy", busy_o, 1);
    chk("wait_pm_ready", sym_ready_o, 0);
    chk("wait_pm_acs", acs_valid_o, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("tbu_start", tbu_start_o, 1);
    repeat (2) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("trace_idle_done", blk_done_o, 0);
      chk("trace_idle_start", tbu_start_o, 0);
    end
    for (int j = 0; j < TBL; j++) begin
      if (gap && j > 0) begin
        drive(1'b1, 1'b0, 1'b0);
        chk("gap_keep", out_keep_o, 0);
        chk("gap_done", blk_done_o, 0);
      end
      drive(1'b1, 1'b0, 1'b1);
      chk("keep", out_keep_o, j >= pad);
      chk("done", blk_done_o, j == TBL - 1);
      chk("trace_ready", sym_ready_o, 0);
      chk("trace_acs", acs_valid_o, 0);
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("ready_back", sym_ready_o, 1);
    chk("busy_back", busy_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    sym_valid_i = 1'b1; sym_last_i = 1'b0; tbu_bit_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outs", outs(), 0);
    sym_valid_i = 1'b0; tbu_bit_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    chk("ready_after_reset", sym_ready_o, 1);
    chk("busy_after_reset", busy_o, 0);

    // Full block, no last.
    feed(TBL, 1'b0, 1'b1, 1'b0);
    trace_blk(0, 1'b0);

    // Short frame: 6 symbols, continuation of the previous frame.
    feed(6, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < TBL - 6; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("flush_acs", acs_valid_o, 1);
      chk("flush_flag", flush_o, 1);
      chk("flush_pm_init", pm_init_o, 0);
      chk("flush_ready", sym_ready_o, 0);
    end
    trace_blk(TBL - 6, 1'b0);

    // Frame of exactly TBL with last, then a 30-symbol frame.
    feed(TBL, 1'b1, 1'b1, 1'b0);
    trace_blk(0, 1'b0);
    feed(TBL, 1'b0, 1'b1, 1'b0);
    trace_blk(0, 1'b0);
    feed(TBL, 1'b1, 1'b0, 1'b0);
    trace_blk(0, 1'b0);

    // Upstream gaps and spaced TBU bits.
    feed(TBL, 1'b0, 1'b1, 1'b1);
    trace_blk(0, 1'b1);

    // TBU hang.
    feed(TBL, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("hang_start", tbu_start_o, 1);
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("hang_done", blk_done_o, k == TB_TIMEOUT);
      chk("hang_err_pre", err_o, 0);
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("hang_err", err_o, 1);
    chk("hang_ready", sym_ready_o, 1);
    chk("hang_busy", busy_o, 0);
    feed(1, 1'b0, 1'b1, 1'b0);
    feed(TBL - 1, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", err_o, 1);

    // Reset mid-trace.
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("rst_blk_start", tbu_start_o, 1);
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b1);
      chk("rst_blk_keep", out_keep_o, 1);
    end
    chk("err_still", err_o, 1);
    @(negedge clk);
    rst_n = 1'b0; sym_valid_i = 1'b1;
    #1;
    chk("reset_trace_outs", outs(), 0);
    @(negedge clk); #1;
    chk("reset_hold_outs", outs(), 0);
    sym_valid_i = 1'b0; tbu_bit_valid_i = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    chk("post_rst_ready", sym_ready_o, 1);
    chk("post_rst_err", err_o, 0);
    feed(1, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Block-level scheduler for the Viterbi decoder datapath. It accepts the received-symbol stream from upstream and generates the ACS/PMU write strobe (`acs_valid_o`) for each trellis step. It groups steps into blocks of TBL and pads a short final block with flush steps. When a block is complete it launches the traceback unit, then holds off input until the TBU has emitted all TBL serial bits, marking which of those bits are real payload.

## Interface
- `TBL`, 15: traceback length in trellis steps; must equal the PMU/TBU `TBL`; legal range ≥ 2.
- `TB_TIMEOUT`, 2*TBL+4: maximum number of cycles spent in TRACE before the block is aborted.
- `CNT_W`, $clog2(TBL+1): width of the step and bit counters.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sym_valid_i`  in  1  upstream symbol valid.
- `sym_last_i`  in  1  the current symbol is the last of its frame; qualified by `sym_valid_i`.
- `sym_ready_o`  out  1  controller can accept a symbol this cycle.
- `acs_valid_o`  out  1  advance the trellis one step; drives BMU/ACSU and the PMU `valid_i`.
- `pm_init_o`  out  1  with `acs_valid_o`: load the initial path metrics (first step of a frame).
- `flush_o`  out  1  with `acs_valid_o`: this is a padding step, and the BMU uses the all-zero symbol.
- `tbu_start_o`  out  1  one-cycle pulse to the TBU `valid_i`.
- `tbu_bit_valid_i`  in  1  TBU `valid_serial_o`.
- `out_keep_o`  out  1  the current TBU serial bit is payload rather than padding.
- `blk_done_o`  out  1  one-cycle pulse when the block finishes.
- `busy_o`  out  1  the state is not ACCUM.
- `err_o`  out  1  sticky traceback-timeout flag; cleared only by reset.

## Operation
- **FSM states:** ACCUM, FLUSH, WAIT_PM, START_TB, TRACE. Reset enters ACCUM.
- **Registers and reset values:** `step_cnt`=0, `bit_cnt`=0, `blk_len`=0, `wd_cnt`=0, `first_r`=1, `err_o`=0.
- **ACCUM:**
  - `sym_ready_o`=1.
  - A fire is `sym_valid_i & sym_ready_o`.
  - On a fire: `acs_valid_o`=1 and `pm_init_o`=`first_r` (both combinational). Then `first_r`←`sym_last_i` and `step_cnt`←`step_cnt`+1.
  - If the new count equals TBL: go to WAIT_PM with `blk_len`←TBL. A `sym_last_i` on this fire still sets `first_r` and does not cause a flush.
  - Else if `sym_last_i`: go to FLUSH with `blk_len`←new count.
- **FLUSH:**
  - `sym_ready_o`=0.
  - Each cycle: `acs_valid_o`=`flush_o`=1 and `step_cnt`++.
  - When the new count equals TBL, go to WAIT_PM.
- **WAIT_PM:** one cycle with no outputs, allowing the PMU write to settle; then go to START_TB.
- **START_TB:** `tbu_start_o`=1 for one cycle; clear `bit_cnt` and `wd_cnt`; go to TRACE.
- **TRACE:**
  - `wd_cnt`++ every cycle.
  - Each `tbu_bit_valid_i` increments `bit_cnt`.
  - `out_keep_o` = `tbu_bit_valid_i & (bit_cnt ≥ TBL−blk_len)`. Traceback emits the newest step first, so padding bits come out first.
  - On the TBL-th bit: `blk_done_o`=1, `step_cnt`←0, go to ACCUM.
  - If `wd_cnt` reaches TB_TIMEOUT first: `err_o`←1, `blk_done_o`=1, `step_cnt`←0, `first_r`←1, go to ACCUM.
- **Outputs outside their states:** `out_keep_o`=0 whenever the state is not TRACE. `tbu_bit_valid_i` outside TRACE is ignored.
- **Output timing:** `sym_ready_o` and `busy_o` are Moore outputs decoded from the state register. `acs_valid_o`, `pm_init_o` and `flush_o` are Mealy outputs.
- **Outputs during reset:** all outputs are 0 except `sym_ready_o`, which is 1 once out of reset.
- **Reset mid-operation:** returns to ACCUM with `first_r`=1. Any pending TBU output is dropped.

## Timing
- `acs_valid_o` is asserted in the same cycle as the accepting fire (zero latency).
- `tbu_start_o` is asserted exactly 2 cycles after the final `acs_valid_o` of a block, counting flush steps.
- Input stall: `sym_ready_o` is 0 from the cycle after the block-completing fire until the cycle after `blk_done_o`.
- Block throughput: TBL accepted steps plus (2 + TBU latency + TBL) stall cycles.
- `blk_done_o` coincides with the TBL-th `tbu_bit_valid_i`.

## Structure
- **Package `viterbi_pkg`:**
  - TBL default and CNT_W.
  - The FSM state enum `vctrl_state_t`.
  - The PM width shared with PMU/TBU.
- **Sub-module `tb_watchdog`:** the `wd_cnt` counter with clear and enable inputs and a timeout output. It is parameterised by TB_TIMEOUT.

## Test plan
All scenarios use TBL=15.
- **Full block:** 15 back-to-back symbols, no last.
  - 15 `acs_valid_o`, the first with `pm_init_o`=1; `tbu_start_o` 2 cycles after the 15th.
  - 15 TBU bits all give `out_keep_o`=1; `blk_done_o` on the 15th; `sym_ready_o` returns to 1.
- **Short frame:** 6 symbols, `sym_last_i` on the 6th.
  - 9 `flush_o` steps, then `tbu_start_o`.
  - TBU bits 0–8 give `out_keep_o`=0 and bits 9–14 give 1.
- **Two frames:** frame of 15 with last, then a new symbol.
  - The new symbol's `acs_valid_o` carries `pm_init_o`=1.
  - A 30-symbol frame gives `pm_init_o` only on symbol 0.
- **Upstream gaps:** `sym_valid_i` toggling 1/0.
  - `acs_valid_o` only on fires; `step_cnt` is unaffected by idle cycles; `sym_ready_o`=0 is respected during TRACE.
- **TBU hang:** `tbu_bit_valid_i` held 0 after start.
  - `err_o`=1 and `blk_done_o` pulse exactly TB_TIMEOUT (34) cycles into TRACE.
  - Back in ACCUM; `err_o` stays 1 until reset.
- **Reset in TRACE:** assert `rst_n`=0 mid-trace.
  - All outputs 0; after release, `sym_ready_o`=1 and the next fire has `pm_init_o`=1.
